uart_fifo_bridge: RTL

Buffered front-end between the CPU bus and the simpleuart data register interface, placed directly upstream of the UART. It holds TX and RX byte FIFOs so software can burst-write without stalling on every byte, and received bytes are not lost while the CPU is busy. It drains TX bytes into the UART with the UART's we/wait handshake, pulls RX bytes out whenever the UART shows valid data, and raises a level-sensitive interrupt.

---
 rtl/uart_fifo_bridge_if.sv | 44 ++++
 rtl/uart_fifo_bridge.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/uart_fifo_bridge_if.sv
// ---------------------------------------------------------------------------
// uart_fifo_bridge_if
//   Bundles the CPU data/control register bus and the simpleuart data
//   register bus that pass through uart_fifo_bridge.
//
//   CPU side   : bus_dat_we/re/di/do/wait, bus_ctrl_we/di, bus_stat_do, irq
//   UART side  : uart_dat_we/di/wait, uart_dat_re/do
//
//   Modports
//     slave  : the bridge itself
//     master : whatever sits around the bridge (CPU and UART together)
// ---------------------------------------------------------------------------
interface uart_fifo_bridge_if;
  // CPU bus
  logic        bus_dat_we;
  logic        bus_dat_re;
  logic [31:0] bus_dat_di;
  logic [31:0] bus_dat_do;
  logic        bus_dat_wait;
  logic        bus_ctrl_we;
  logic [31:0] bus_ctrl_di;
  logic [31:0] bus_stat_do;
  logic        irq;
  // simpleuart data register bus
  logic        uart_dat_we;
  logic [31:0] uart_dat_di;
  logic        uart_dat_wait;
  logic        uart_dat_re;
  logic [31:0] uart_dat_do;

  modport slave (
    input  bus_dat_we, bus_dat_re, bus_dat_di, bus_ctrl_we, bus_ctrl_di,
    input  uart_dat_wait, uart_dat_do,
    output bus_dat_do, bus_dat_wait, bus_stat_do, irq,
    output uart_dat_we, uart_dat_di, uart_dat_re
  );

  modport master (
    output bus_dat_we, bus_dat_re, bus_dat_di, bus_ctrl_we, bus_ctrl_di,
    output uart_dat_wait, uart_dat_do,
    input  bus_dat_do, bus_dat_wait, bus_stat_do, irq,
    input  uart_dat_we, uart_dat_di, uart_dat_re
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// ---------------------------------------------------------------------------
// uart_fifo_bridge
//   TX and RX byte FIFOs between the CPU data register bus and simpleuart.
//   CPU writes are buffered and drained into the UART; bytes the UART shows
//   as valid are pulled into the RX FIFO for the CPU to read later. A
//   registered, level-sensitive interrupt reports RX fill and TX empty.
//
// Ports
//   clk, resetn : clock, asynchronous active-low reset
//   bus.slave   : CPU data/control/status registers and irq, plus the
//                 simpleuart data register bus (see uart_fifo_bridge_if)
//
// Handshakes (all sampled on the rising clk edge):
//   - CPU TX write : transfer when bus_dat_we && !bus_dat_wait.
//   - UART TX      : transfer when uart_dat_we && !uart_dat_wait; we holds
//                    while data is queued, di is the queue head.
//   - UART RX      : uart_dat_re is a single-cycle take strobe asserted when
//                    uart_dat_do[31] is 0 and there is room; the byte is
//                    captured on that same edge.
//   - CPU RX read  : bus_dat_do shows the head; bus_dat_re pops it.
// ---------------------------------------------------------------------------
module uart_fifo_bridge #(
  parameter int DEPTH_LOG2   = 4,
  parameter int RX_IRQ_LEVEL = 1
) (
  input logic               clk,
  input logic               resetn,
  uart_fifo_bridge_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;

  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];
  ptr_t       tx_wr, tx_rd, rx_wr, rx_rd;
  cnt_t       tx_count, rx_count;
  logic       rx_ie, tx_ie, irq_q;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_flush, rx_flush;
  logic tx_push, tx_pop, rx_take, rx_pop;
  logic irq_next;

  assign tx_full  = (tx_count == cnt_t'(DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == cnt_t'(DEPTH));
  assign rx_empty = (rx_count == '0);

  assign tx_flush = bus.bus_ctrl_we && bus.bus_ctrl_di[3];
  assign rx_flush = bus.bus_ctrl_we && bus.bus_ctrl_di[2];

  assign tx_push = bus.bus_dat_we && !tx_full;
  assign tx_pop  = !tx_empty && !bus.uart_dat_wait;
  // Gated by resetn so the UART is never told to drop a byte during reset.
  assign rx_take = resetn && !bus.uart_dat_do[31] && !rx_full;
  assign rx_pop  = bus.bus_dat_re && !rx_empty;

  // A write landing in a TX flush cycle is accepted and thrown away, so the
  // CPU is never held even if the FIFO was full before the flush.
  assign bus.bus_dat_wait = bus.bus_dat_we && tx_full && !tx_flush;

  assign bus.uart_dat_we = !tx_empty;
  assign bus.uart_dat_di = {24'h0, tx_mem[tx_rd]};
  assign bus.uart_dat_re = rx_take;

  assign bus.bus_dat_do  = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_mem[rx_rd]};
  assign bus.bus_stat_do = {10'h0, tx_ie, rx_ie, tx_full, tx_empty,
                            rx_full, rx_empty, 8'(tx_count), 8'(rx_count)};
  assign bus.irq = irq_q;

  // Storage carries no reset: contents are only visible through the counts.
  always_ff @(posedge clk) begin
    if (tx_push && !tx_flush) tx_mem[tx_wr] <= bus.bus_dat_di[7:0];
    if (rx_take && !rx_flush) rx_mem[rx_wr] <= bus.uart_dat_do[7:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else if (tx_flush) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + ptr_t'(1);
      if (tx_pop)  tx_rd <= tx_rd + ptr_t'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + cnt_t'(1);
        2'b01:   tx_count <= tx_count - cnt_t'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else if (rx_flush) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_take) rx_wr <= rx_wr + ptr_t'(1);
      if (rx_pop)  rx_rd <= rx_rd + ptr_t'(1);
      case ({rx_take, rx_pop})
        2'b10:   rx_count <= rx_count + cnt_t'(1);
        2'b01:   rx_count <= rx_count - cnt_t'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Interrupt reflects the pre-edge state, hence one cycle behind the FIFOs.
  always_comb begin
    irq_next = 1'b0;
    if (rx_ie && (rx_count >= cnt_t'(RX_IRQ_LEVEL))) irq_next = 1'b1;
    if (tx_ie && tx_empty)                          irq_next = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_next;
      if (bus.bus_ctrl_we) begin
        rx_ie <= bus.bus_ctrl_di[0];
        tx_ie <= bus.bus_ctrl_di[1];
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.bus_dat_di[31:8], bus.bus_ctrl_di[31:4],
                         bus.uart_dat_do[30:8]};
endmodule
